row_window_feeder: RTL and testbench

Streams a stored generation out of the frame row memory as consecutive three-row windows (top, middle, bottom) for the combinational next-state row array. It issues row reads, keeps a sliding window plus a one-row prefetch so a new window can be accepted every cycle, and supplies the vertical boundary rows. It sits between the frame memory read port and the next-state array inputs; row index and handshake travel with each window to the write-back stage.

---
 rtl/row_window_feeder.sv | 164 ++++++++++++++++
 tb/tb_row_window_feeder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/row_window_feeder.sv
// row_window_feeder: streams a stored frame as consecutive top/middle/bottom row windows.
// Build option `WRAP_EN selects a vertical toroidal boundary; otherwise out-of-frame rows are zero.
module row_window_feeder #(
  parameter int ROW_LENGTH = 1280,
  parameter int NUM_ROWS   = 720,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [ROW_LENGTH-1:0] mem_rd_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [ROW_LENGTH-1:0] top_row,
  output logic [ROW_LENGTH-1:0] middle_row,
  output logic [ROW_LENGTH-1:0] bottom_row,
  output logic [ADDR_WIDTH-1:0] win_row_idx
);

  localparam int RW = ADDR_WIDTH + 1;
`ifdef WRAP_EN
  localparam int PRIME_READS = 4;
  localparam int READ_LIMIT  = NUM_ROWS + 1;
  localparam logic [RW-1:0] FIRST_ROW  = RW'(NUM_ROWS - 1);
  localparam logic [RW-1:0] FIRST_NEXT = RW'(0);
`else
  localparam int PRIME_READS = 3;
  localparam int READ_LIMIT  = NUM_ROWS;
  localparam logic [RW-1:0] FIRST_ROW  = RW'(0);
  localparam logic [RW-1:0] FIRST_NEXT = RW'(1);
`endif
  localparam logic [RW-1:0]         N_RW      = RW'(NUM_ROWS);
  localparam logic [RW-1:0]         LIMIT_RW  = RW'(READ_LIMIT);
  localparam logic [RW-1:0]         PRIME_END = RW'(3);
  localparam logic [2:0]            PRIME_LAST = 3'(PRIME_READS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_ROWS - 1);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  state_t                state;
  logic                  data_vld;
  logic                  pf_full;
  logic [ROW_LENGTH-1:0] prefetch;
  logic [ROW_LENGTH-1:0] next_bottom;
  logic [RW-1:0]         next_row;
  logic [2:0]            cap_cnt;
  logic                  hs;

  // Frame row number (may run one past the end) to memory address.
  function automatic logic [ADDR_WIDTH-1:0] row_addr(input logic [RW-1:0] row);
    if (row >= N_RW) return ADDR_WIDTH'(row - N_RW);
    return ADDR_WIDTH'(row);
  endfunction

  assign hs = win_valid && win_ready;

  // Row i+2 is either parked in prefetch or arriving from memory this cycle; neither means past the frame.
  always_comb begin
    next_bottom = '0;
    if (pf_full)       next_bottom = prefetch;
    else if (data_vld) next_bottom = mem_rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      win_valid   <= 1'b0;
      win_row_idx <= '0;
      top_row     <= '0;
      middle_row  <= '0;
      bottom_row  <= '0;
      prefetch    <= '0;
      pf_full     <= 1'b0;
      data_vld    <= 1'b0;
      next_row    <= '0;
      cap_cnt     <= '0;
    end else begin
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      data_vld  <= mem_rd_en;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= PRIME;
            busy        <= 1'b1;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= row_addr(FIRST_ROW);
            next_row    <= FIRST_NEXT;
            cap_cnt     <= '0;
          end
        end
        PRIME: begin
          if (next_row < PRIME_END) begin
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= row_addr(next_row);
            next_row    <= next_row + 1'b1;
          end
          // Captures ripple through the window so the rows settle in top/middle/bottom/prefetch order.
          if (data_vld) begin
            top_row    <= middle_row;
            middle_row <= bottom_row;
            bottom_row <= prefetch;
            prefetch   <= mem_rd_data;
            cap_cnt    <= cap_cnt + 1'b1;
            if (cap_cnt == PRIME_LAST) begin
              state       <= STREAM;
              win_valid   <= 1'b1;
              win_row_idx <= '0;
              pf_full     <= 1'b1;
              if (next_row < LIMIT_RW) begin
                mem_rd_en   <= 1'b1;
                mem_rd_addr <= row_addr(next_row);
                next_row    <= next_row + 1'b1;
              end
            end
          end
        end
        STREAM: begin
          if (data_vld && !hs) begin
            prefetch <= mem_rd_data;
            pf_full  <= 1'b1;
          end
          if (hs) begin
            if (win_row_idx == LAST_IDX) begin
              state       <= IDLE;
              busy        <= 1'b0;
              done        <= 1'b1;
              win_valid   <= 1'b0;
              win_row_idx <= '0;
              top_row     <= '0;
              middle_row  <= '0;
              bottom_row  <= '0;
              prefetch    <= '0;
              pf_full     <= 1'b0;
              next_row    <= '0;
            end else begin
              top_row     <= middle_row;
              middle_row  <= bottom_row;
              bottom_row  <= next_bottom;
              pf_full     <= 1'b0;
              win_row_idx <= win_row_idx + 1'b1;
              // One read per newly presented window, so a stalled window never re-reads.
              if (next_row < LIMIT_RW) begin
                mem_rd_en   <= 1'b1;
                mem_rd_addr <= row_addr(next_row);
                next_row    <= next_row + 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_window_feeder.sv
// Directed bench for row_window_feeder: 8-cell rows, 4-row frame, rows r0..r3 = 11/22/44/88.
// Define WRAP_EN for both design and bench to switch the expected boundary rows.
`timescale 1ns/1ps
module tb_row_window_feeder;
  localparam int RL = 8;
  localparam int NR = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          win_ready = 1'b0;
  logic          busy, done, mem_rd_en, win_valid;
  logic [AW-1:0] mem_rd_addr, win_row_idx;
  logic [RL-1:0] mem_rd_data;
  logic [RL-1:0] top_row, middle_row, bottom_row;

  logic [RL-1:0] mem [NR];
  logic [AW-1:0] rd_log [64];
  int            rd_cnt = 0;
  int            total = 0;
  int            bad = 0;
  logic [31:0]   exp_win [NR];
  logic [31:0]   exp_reads;
  int            exp_nreads;
  int            exp_lat;

  always #5 clk = ~clk;

  row_window_feeder #(.ROW_LENGTH(RL), .NUM_ROWS(NR), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .win_valid(win_valid), .win_ready(win_ready),
    .top_row(top_row), .middle_row(middle_row), .bottom_row(bottom_row),
    .win_row_idx(win_row_idx)
  );

  // Frame memory: data valid the cycle after the strobe; every read is logged.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data        <= mem[mem_rd_addr];
      rd_log[6'(rd_cnt)] <= mem_rd_addr;
      rd_cnt             <= rd_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] win_word();
    return {6'd0, win_row_idx, top_row, middle_row, bottom_row};
  endfunction

  // Pulse start for the next edge, then count edges until the first window appears.
  task automatic kick_start(output int lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!win_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("first_valid_seen", 32'(win_valid), 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat, base, n_got, n_done;
    logic [31:0] seq;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h44; mem[3] = 8'h88;
`ifdef WRAP_EN
    exp_win[0] = 32'h00881122; exp_win[1] = 32'h01112244;
    exp_win[2] = 32'h02224488; exp_win[3] = 32'h03448811;
    exp_reads = 32'h00301230; exp_nreads = 6; exp_lat = 5;
`else
    exp_win[0] = 32'h00001122; exp_win[1] = 32'h01112244;
    exp_win[2] = 32'h02224488; exp_win[3] = 32'h03448800;
    exp_reads = 32'h00000123; exp_nreads = 4; exp_lat = 4;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ctrl", {26'd0, busy, done, mem_rd_en, win_valid, mem_rd_addr}, 32'd0);
    check("rst_win", win_word(), 32'd0);
    rst = 1'b0;
    win_ready = 1'b1;
    @(negedge clk);

    // Free-running pass
    base = rd_cnt;
    kick_start(lat);
    check("free_latency", 32'(lat), 32'(exp_lat));
    check("free_busy", 32'(busy), 32'd1);
    for (int i = 0; i < NR; i++) begin
      check($sformatf("free_win%0d", i), win_word(), exp_win[i]);
      @(negedge clk);
    end
    check("free_done", {29'd0, busy, done, win_valid}, 32'b010);
    @(negedge clk);
    check("free_done_width", 32'(done), 32'd0);
    check("free_nreads", 32'(rd_cnt - base), 32'(exp_nreads));
    seq = '0;
    for (int i = base; i < rd_cnt; i++) seq = (seq << 4) | 32'(rd_log[6'(i)]);
    check("free_read_addrs", seq, exp_reads);

    // Stall on window 1 for three cycles
    kick_start(lat);
    check("stall_w0", win_word(), exp_win[0]);
    @(negedge clk);
    check("stall_w1", win_word(), exp_win[1]);
    win_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall_hold%0d", k), win_word(), exp_win[1]);
      check($sformatf("stall_no_rd%0d", k), 32'(mem_rd_en), 32'd0);
    end
    win_ready = 1'b1;
    @(negedge clk);
    check("stall_w2", win_word(), exp_win[2]);
    @(negedge clk);
    check("stall_w3", win_word(), exp_win[3]);
    @(negedge clk);
    check("stall_done", 32'(done), 32'd1);

    // Back-to-back start in the done cycle, then alternating win_ready
    win_ready = 1'b0;
    kick_start(lat);
    check("b2b_latency", 32'(lat), 32'(exp_lat));
    n_got = 0;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      win_ready = (c % 2 == 0);
      if (done) n_done++;
      if (win_valid && win_ready) begin
        if (n_got < NR) check($sformatf("alt_win%0d", n_got), win_word(), exp_win[n_got]);
        n_got++;
      end
      @(negedge clk);
    end
    check("alt_count", 32'(n_got), 32'(NR));
    check("alt_done_count", 32'(n_done), 32'd1);
    check("alt_idle", {30'd0, busy, win_valid}, 32'd0);

    // Asynchronous reset during window 2
    win_ready = 1'b1;
    kick_start(lat);
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_pre_idx", 32'(win_row_idx), 32'd2);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ctrl", {26'd0, busy, done, mem_rd_en, win_valid, mem_rd_addr}, 32'd0);
    check("mid_rst_win", win_word(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    kick_start(lat);
    check("post_rst_latency", 32'(lat), 32'(exp_lat));
    check("post_rst_w0", win_word(), exp_win[0]);
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("post_rst_done_count", 32'(n_done), 32'd1);

    // start while busy is ignored
    kick_start(lat);
    check("busy_start_w0", win_word(), exp_win[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_w1", win_word(), exp_win[1]);
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("busy_start_done_count", 32'(n_done), 32'd1);
    check("busy_start_idle", {30'd0, busy, win_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
